// File: rtl/cpu_axi_bridge_pkg.sv
// Shared types and constants for the SRAM-like to AXI bridge: FSM state
// encodings, default transaction ids and field widths.
package cpu_axi_bridge_pkg;

    localparam int AXI_ID_W    = 4;
    localparam int SRAM_SIZE_W = 2;
    localparam int AXI_SIZE_W  = 3;

    localparam logic [AXI_ID_W-1:0] INST_ID_DEF = 4'd0;
    localparam logic [AXI_ID_W-1:0] DATA_ID_DEF = 4'd1;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_AR   = 2'd1,
        RD_R    = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_AWW  = 2'd1,
        WR_B    = 2'd2
    } wr_state_e;

    // SRAM size is log2(bytes); AXI size uses the same encoding one bit wider.
    function automatic logic [AXI_SIZE_W-1:0] axi_size(input logic [SRAM_SIZE_W-1:0] s);
        return {1'b0, s};
    endfunction

endpackage

// File: rtl/cpu_axi_bridge_if.sv
// AXI read/write channel bundle between the bridge (master) and the interconnect (slave).
// Handshake: a transfer happens on a rising clk edge where valid and ready are both 1;
// the source holds payload stable while valid is high and ready is low.
interface cpu_axi_bridge_if;
    import cpu_axi_bridge_pkg::*;

    logic [AXI_ID_W-1:0]   arid;
    logic [31:0]           araddr;
    logic [AXI_SIZE_W-1:0] arsize;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [31:0]           rdata;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           awaddr;
    logic [AXI_SIZE_W-1:0] awsize;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output arid, araddr, arsize, arvalid, rready,
        output awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rid, rdata, rvalid, awready, wready, bvalid
    );

    modport slave (
        input  arid, araddr, arsize, arvalid, rready,
        input  awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rid, rdata, rvalid, awready, wready, bvalid
    );

endinterface

// File: rtl/cpu_axi_bridge_wr.sv
// Write channel engine: latches one data-port write, drives AW and W independently,
// acknowledges the core once both are accepted, then waits for the B response.
module cpu_axi_bridge_wr
    import cpu_axi_bridge_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   req_i,
    input  logic                   wr_i,
    input  logic                   block_i,
    input  logic [SRAM_SIZE_W-1:0] size_i,
    input  logic [3:0]             wstrb_i,
    input  logic [31:0]            addr_i,
    input  logic [31:0]            wdata_i,
    output logic                   addr_ok_o,
    output logic                   data_ok_o,
    output logic                   idle_o,
    output wr_state_e              state_o,
    output logic [31:0]            awaddr_o,
    output logic [AXI_SIZE_W-1:0]  awsize_o,
    output logic                   awvalid_o,
    input  logic                   awready_i,
    output logic [31:0]            wdata_o,
    output logic [3:0]             wstrb_o,
    output logic                   wvalid_o,
    input  logic                   wready_i,
    input  logic                   bvalid_i,
    output logic                   bready_o
);

    wr_state_e              state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             wstrb_q, wstrb_d;
    logic [SRAM_SIZE_W-1:0] size_q, size_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        size_d    = size_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awvalid_o = 1'b0;
        wvalid_o  = 1'b0;
        bready_o  = 1'b0;
        addr_ok_o = 1'b0;
        data_ok_o = 1'b0;
        case (state_q)
            WR_IDLE: begin
                if (req_i && wr_i && !block_i) begin
                    addr_d    = addr_i;
                    wdata_d   = wdata_i;
                    wstrb_d   = wstrb_i;
                    size_d    = size_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_AWW;
                end
            end
            WR_AWW: begin
                awvalid_o = !aw_done_q;
                wvalid_o  = !w_done_q;
                if (!aw_done_q && awready_i) aw_done_d = 1'b1;
                if (!w_done_q && wready_i)   w_done_d  = 1'b1;
                // Both channels may complete in the same cycle or in either order.
                if (aw_done_d && w_done_d) begin
                    addr_ok_o = 1'b1;
                    state_d   = WR_B;
                end
            end
            WR_B: begin
                bready_o = 1'b1;
                if (bvalid_i) begin
                    data_ok_o = 1'b1;
                    state_d   = WR_IDLE;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= WR_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            size_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            size_q    <= size_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign idle_o   = (state_q == WR_IDLE);
    assign state_o  = state_q;
    assign awaddr_o = addr_q;
    assign awsize_o = axi_size(size_q);
    assign wdata_o  = wdata_q;
    assign wstrb_o  = wstrb_q;

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's instruction and data SRAM-like ports onto one AXI master:
// read arbitration and read FSM live here, writes go through cpu_axi_bridge_wr.
module cpu_axi_bridge
    import cpu_axi_bridge_pkg::*;
#(
    parameter logic [AXI_ID_W-1:0] INST_ID = INST_ID_DEF,
    parameter logic [AXI_ID_W-1:0] DATA_ID = DATA_ID_DEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   inst_sram_req,
    input  logic [SRAM_SIZE_W-1:0] inst_sram_size,
    input  logic [31:0]            inst_sram_addr,
    output logic                   inst_sram_addr_ok,
    output logic                   inst_sram_data_ok,
    output logic [31:0]            inst_sram_rdata,
    input  logic                   data_sram_req,
    input  logic                   data_sram_wr,
    input  logic [SRAM_SIZE_W-1:0] data_sram_size,
    input  logic [3:0]             data_sram_wstrb,
    input  logic [31:0]            data_sram_addr,
    input  logic [31:0]            data_sram_wdata,
    output logic                   data_sram_addr_ok,
    output logic                   data_sram_data_ok,
    output logic [31:0]            data_sram_rdata,
    cpu_axi_bridge_if.master       axi,
    output rd_state_e              dbg_rd_state,
    output wr_state_e              dbg_wr_state
);

    rd_state_e              rd_state_q, rd_state_d;
    logic [AXI_ID_W-1:0]    rd_id_q, rd_id_d;
    logic [31:0]            rd_addr_q, rd_addr_d;
    logic [SRAM_SIZE_W-1:0] rd_size_q, rd_size_d;
    logic                   rd_arvalid, rd_rready;
    logic                   inst_aok, inst_dok, data_rd_aok, data_rd_dok;
    logic                   rd_holds_data;
    logic                   wr_idle, wr_addr_ok, wr_data_ok;
    logic [31:0]            wr_awaddr, wr_wdata;
    logic [AXI_SIZE_W-1:0]  wr_awsize;
    logic [3:0]             wr_wstrb;
    logic                   wr_awvalid, wr_wvalid, wr_bready;

    // A data write must not overtake a data read still in flight.
    assign rd_holds_data = (rd_state_q != RD_IDLE) && (rd_id_q == DATA_ID);

    always_comb begin
        rd_state_d  = rd_state_q;
        rd_id_d     = rd_id_q;
        rd_addr_d   = rd_addr_q;
        rd_size_d   = rd_size_q;
        rd_arvalid  = 1'b0;
        rd_rready   = 1'b0;
        inst_aok    = 1'b0;
        inst_dok    = 1'b0;
        data_rd_aok = 1'b0;
        data_rd_dok = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                // Data reads win, but only once no write is pending on the data port.
                if (data_sram_req && !data_sram_wr && wr_idle) begin
                    rd_id_d    = DATA_ID;
                    rd_addr_d  = data_sram_addr;
                    rd_size_d  = data_sram_size;
                    rd_state_d = RD_AR;
                end else if (inst_sram_req) begin
                    rd_id_d    = INST_ID;
                    rd_addr_d  = inst_sram_addr;
                    rd_size_d  = inst_sram_size;
                    rd_state_d = RD_AR;
                end
            end
            RD_AR: begin
                rd_arvalid = 1'b1;
                if (axi.arready) begin
                    inst_aok    = (rd_id_q == INST_ID);
                    data_rd_aok = (rd_id_q == DATA_ID);
                    rd_state_d  = RD_R;
                end
            end
            RD_R: begin
                rd_rready = 1'b1;
                if (axi.rvalid) begin
                    if (axi.rid == rd_id_q) begin
                        inst_dok    = (rd_id_q == INST_ID);
                        data_rd_dok = (rd_id_q == DATA_ID);
                    end
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state_q <= RD_IDLE;
            rd_id_q    <= '0;
            rd_addr_q  <= '0;
            rd_size_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_id_q    <= rd_id_d;
            rd_addr_q  <= rd_addr_d;
            rd_size_q  <= rd_size_d;
        end
    end

    cpu_axi_bridge_wr u_wr (
        .clk       (clk),
        .resetn    (resetn),
        .req_i     (data_sram_req),
        .wr_i      (data_sram_wr),
        .block_i   (rd_holds_data),
        .size_i    (data_sram_size),
        .wstrb_i   (data_sram_wstrb),
        .addr_i    (data_sram_addr),
        .wdata_i   (data_sram_wdata),
        .addr_ok_o (wr_addr_ok),
        .data_ok_o (wr_data_ok),
        .idle_o    (wr_idle),
        .state_o   (dbg_wr_state),
        .awaddr_o  (wr_awaddr),
        .awsize_o  (wr_awsize),
        .awvalid_o (wr_awvalid),
        .awready_i (axi.awready),
        .wdata_o   (wr_wdata),
        .wstrb_o   (wr_wstrb),
        .wvalid_o  (wr_wvalid),
        .wready_i  (axi.wready),
        .bvalid_i  (axi.bvalid),
        .bready_o  (wr_bready)
    );

    assign axi.arid    = rd_id_q;
    assign axi.araddr  = rd_addr_q;
    assign axi.arsize  = axi_size(rd_size_q);
    assign axi.arvalid = rd_arvalid;
    assign axi.rready  = rd_rready;
    assign axi.awaddr  = wr_awaddr;
    assign axi.awsize  = wr_awsize;
    assign axi.awvalid = wr_awvalid;
    assign axi.wdata   = wr_wdata;
    assign axi.wstrb   = wr_wstrb;
    assign axi.wvalid  = wr_wvalid;
    assign axi.bready  = wr_bready;

    assign inst_sram_addr_ok = inst_aok;
    assign inst_sram_data_ok = inst_dok;
    assign inst_sram_rdata   = axi.rdata;
    // Ordering rules keep a data read and a data write from acknowledging together.
    assign data_sram_addr_ok = data_rd_aok | wr_addr_ok;
    assign data_sram_data_ok = data_rd_dok | wr_data_ok;
    assign data_sram_rdata   = axi.rdata;
    assign dbg_rd_state      = rd_state_q;

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
Converts the core's two SRAM-like master ports (instruction and data, req/addr_ok/data_ok protocol) into one AXI master interface. Sits directly below the CPU core top, between the core and the AXI interconnect/RAM.
Arbitrates reads between the two ports. Serialises writes. Enforces data-port read/write ordering. At most one read and one write transaction are outstanding at a time.

Parameters:
INST_ID, 4'd0, arid/rid value tagging instruction reads
DATA_ID, 4'd1, arid/rid value tagging data reads

Ports:
clk  in  1  clock
resetn  in  1  asynchronous, active-low reset
inst_sram_req  in  1  instruction read request
inst_sram_size  in  2  log2 bytes
inst_sram_addr  in  32  read address
inst_sram_addr_ok  out  1  request accepted
inst_sram_data_ok  out  1  read data valid
inst_sram_rdata  out  32  read data
data_sram_req  in  1  data request
data_sram_wr  in  1  1=write, 0=read
data_sram_size  in  2  log2 bytes
data_sram_wstrb  in  4  byte strobes
data_sram_addr  in  32  address
data_sram_wdata  in  32  write data
data_sram_addr_ok  out  1  request accepted
data_sram_data_ok  out  1  read data valid / write done
data_sram_rdata  out  32  read data
arid  out  4  read id
araddr  out  32  read address
arsize  out  3  {1'b0,size}
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  returned id
rdata  in  32  returned data
rvalid  in  1  R valid
rready  out  1  R ready
awaddr  out  32  write address
awsize  out  3  {1'b0,size}
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  32  write data
wstrb  out  4  write strobes
wvalid  out  1  W valid
wready  in  1  W ready
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- Inst port is read-only: the core's inst_sram_wr/wstrb/wdata are not connected.
- Constant AXI fields (len=0, burst=INCR, lock/cache/prot=0, awid=1, wlast=1) are tied off in the SoC wrapper, not in this block.
- Read FSM, states RD_IDLE -> RD_AR -> RD_R:
  - In RD_IDLE, a data read wins over an inst read.
  - The selected request's id/addr/size are latched on leaving RD_IDLE, and the FSM moves to RD_AR.
  - RD_AR: arvalid=1. On arvalid&arready, pulse addr_ok to the latched source in that same cycle, then move to RD_R.
  - RD_R: rready=1. On rvalid, data_ok=(rid==source id) and rdata is passed through combinationally, then return to RD_IDLE.
  - Read latency from request in RD_IDLE is at least 3 cycles.
- Write FSM, states WR_IDLE -> WR_AWW -> WR_B:
  - In WR_IDLE, a data_sram_req with wr=1 latches addr/size/wstrb/wdata and moves to WR_AWW.
  - WR_AWW: awvalid and wvalid are both raised. Each drops independently after its own handshake, tracked by flags aw_done/w_done.
  - When both handshakes are done (including same cycle), pulse data_sram_addr_ok and move to WR_B.
  - WR_B: bready=1. On bvalid, pulse data_sram_data_ok and return to WR_IDLE. bresp is ignored.
- Ordering (data port):
  - A data read is not started while the write FSM is not in WR_IDLE.
  - A data write is not started while the read FSM holds a data read (RD_AR/RD_R with id=DATA_ID).
  - Inst reads are never blocked by writes.
- Only one data-port request is taken at a time: no new data request is latched until the previous data transaction's data_ok.
- addr_ok and data_ok are never asserted in the same cycle for the same request.
- Reset (resetn=0, async): both FSMs go idle; arvalid, awvalid, wvalid, rready, bready, all addr_ok/data_ok = 0; latched registers = 0. Reset mid-transaction abandons it with no response.
- Masters hold req/addr stable until addr_ok. The bridge samples them only in the idle states.

Decomposition:
- Shared package (width.vh style defines): read/write FSM state encodings, INST_ID/DATA_ID defaults, AXI size widths.
- One natural sub-module: cpu_axi_bridge_wr, holding the write FSM with aw_done/w_done. The read FSM and arbitration stay in the top.

Test Plan:
- Inst read 0x1c000000, arready=1 on the first cycle, rvalid 2 cycles later with rdata=0x02800c0c, rid=0 -> inst addr_ok one pulse, inst data_ok one pulse with rdata=0x02800c0c; data port idle.
- Inst and data reads in the same cycle -> arid=1 is issued first; the inst read starts only after the data rvalid; each data_ok goes only to its own port.
- Data write addr 0x100, wstrb=4'b0011, wdata=0xdeadbeef; awready at cycle 1, wready at cycle 3 -> awvalid drops after cycle 1, data addr_ok at cycle 3, data_ok on bvalid.
- Write 0x100 in WR_B plus a data read of 0x100 requested -> arvalid stays 0 until bvalid, then the read is issued; a concurrent inst read proceeds unaffected.
- resetn deasserted while in RD_R and WR_AWW -> all valid/ready/ok outputs are 0 immediately, asynchronously; after release, a fresh inst read completes normally.
